// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing defaults for the pushbutton conditioner.
package key_pkg;

  localparam int unsigned DB_10MS   = 500000;
  localparam int unsigned REP_500MS = 25000000;
  localparam int unsigned REP_100MS = 5000000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop synchronizer, debounce FSM, press/release pulses
// and optional auto-repeat while held.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_10MS,
  parameter int unsigned REP_DELAY  = REP_500MS,
  parameter int unsigned REP_PERIOD = REP_100MS,
  parameter bit          REP_ON     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic repeat_pulse_o
);

  localparam int unsigned CW    = cnt_width(DB_CYCLES);
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW    = cnt_width(REP_MAX);

  localparam logic [CW-1:0] DB_LAST        = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REP_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic          s_c;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          first_q, first_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // Plain flop chain; idle level is high (key released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      first_q   <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      first_q   <= first_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    first_d   = first_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_c) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
          rcnt_d  = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s_c) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REP_ON) begin
          // First repeat waits the long delay, later ones the short period.
          if (rcnt_q == (first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            first_d  = 1'b0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s_c) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign repeat_pulse_o  = REP_ON ? repeat_q : 1'b0;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw active-low pushbuttons into debounced levels and
// one-cycle press/release/repeat pulses, one independent channel per key.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned      NKEYS      = 4,
  parameter int unsigned      DB_CYCLES  = DB_10MS,
  parameter int unsigned      REP_DELAY  = REP_500MS,
  parameter int unsigned      REP_PERIOD = REP_100MS,
  parameter logic [NKEYS-1:0] REP_EN     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] key,
  output logic [NKEYS-1:0] pressed,
  output logic [NKEYS-1:0] press_pulse,
  output logic [NKEYS-1:0] release_pulse,
  output logic [NKEYS-1:0] repeat_pulse
);

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_channel #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD),
      .REP_ON    (REP_EN[g])
    ) u_chan (
      .clk            (clock),
      .rst_n          (reset),
      .key_n_i        (key[g]),
      .pressed_o      (pressed[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .repeat_pulse_o (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner against a run-length
// behavioural model of debounce and auto-repeat.
module tb_key_conditioner;

  localparam int unsigned NK = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
  localparam logic [NK-1:0] REN = 4'b0010;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK-1:0] key;
  logic [NK-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clock = ~clock;

  key_conditioner #(
    .NKEYS     (NK),
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP),
    .REP_EN    (REN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  // Model: a level flips once DB+1 consecutive samples disagree with it.
  // Repeats fire after RD, RD+RP, RD+2RP... held samples that agree with
  // the level while no release run is in progress.
  logic [NK-1:0] m_d1, m_d2, m_lvl, e_press, e_rel, e_rep;
  int unsigned   run [NK];
  int unsigned   held[NK];
  int unsigned   tgt [NK];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_d1    <= '1;
      m_d2    <= '1;
      m_lvl   <= '0;
      e_press <= '0;
      e_rel   <= '0;
      e_rep   <= '0;
      for (int k = 0; k < NK; k++) begin
        run[k]  <= 0;
        held[k] <= 0;
        tgt[k]  <= RD;
      end
    end else begin
      m_d1 <= key;
      m_d2 <= m_d1;
      for (int k = 0; k < NK; k++) begin
        e_press[k] <= 1'b0;
        e_rel[k]   <= 1'b0;
        e_rep[k]   <= 1'b0;
        if ((~m_d2[k]) != m_lvl[k]) begin
          if (run[k] == DB) begin
            m_lvl[k] <= ~m_lvl[k];
            run[k]   <= 0;
            if (m_lvl[k]) begin
              e_rel[k] <= 1'b1;
            end else begin
              e_press[k] <= 1'b1;
              held[k]    <= 0;
              tgt[k]     <= RD;
            end
          end else begin
            run[k] <= run[k] + 1;
          end
        end else begin
          run[k] <= 0;
          if (m_lvl[k] && run[k] == 0 && REN[k]) begin
            held[k] <= held[k] + 1;
            if (held[k] + 1 == tgt[k]) begin
              e_rep[k] <= 1'b1;
              tgt[k]   <= tgt[k] + RP;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    chk(nm, 16'(act), 16'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (cmp_on)
      chk("model", {pressed, press_pulse, release_pulse, repeat_pulse},
          {m_lvl, e_press, e_rel, e_rep});
  end

  logic [NK-1:0] acc;
  int unsigned   tmr[NK];

  initial begin
    reset = 1'b0;
    key   = '1;
    cyc(3);
    chk("reset_state", {pressed, press_pulse, release_pulse, repeat_pulse}, 16'h0000);
    reset  = 1'b1;
    cmp_on = 1'b1;
    cyc(5);

    // Clean press on key 0: pulse after the 7th sampling edge.
    key = 4'b1110;
    cyc(6);
    chk4("press_early", pressed, 4'b0000);
    cyc(1);
    chk4("press_pulse", press_pulse, 4'b0001);
    chk4("press_level", pressed, 4'b0001);
    chk("press_quiet", 16'({release_pulse, repeat_pulse}), 16'h0000);
    cyc(1);
    chk4("press_once", press_pulse, 4'b0000);
    chk4("press_held", pressed, 4'b0001);
    key = '1;
    cyc(7);
    chk4("release_pulse", release_pulse, 4'b0001);
    chk4("release_level", pressed, 4'b0000);
    cyc(10);

    // Bounce: 3 low, 1 high, 3 low, then high; never accepted.
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      key[0] = (i == 3 || i >= 7);
      cyc(1);
      acc |= pressed | press_pulse;
    end
    chk4("bounce", acc, 4'b0000);

    // Release with glitch: high 2, low 1, then high for good.
    key[0] = 1'b0;
    cyc(12);
    chk4("glitch_pre", pressed, 4'b0001);
    key[0] = 1'b1;
    cyc(2);
    key[0] = 1'b0;
    cyc(1);
    chk4("glitch_mid", pressed, 4'b0001);
    key[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      if (i < 7) begin
        chk4("glitch_hold", pressed, 4'b0001);
        chk4("glitch_norel", release_pulse, 4'b0000);
      end else begin
        chk4("glitch_rel", release_pulse, 4'b0001);
      end
    end
    cyc(1);
    chk4("glitch_rel_once", release_pulse, 4'b0000);
    cyc(10);

    // Auto-repeat: keys 0 and 1 held 40 cycles, only key 1 repeats.
    key = 4'b1100;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      chk4("rep_press", press_pulse, (i == 7) ? 4'b0011 : 4'b0000);
      chk4("rep_pulse", repeat_pulse,
           (i >= 17 && i <= 41 && (i - 17) % 3 == 0) ? 4'b0010 : 4'b0000);
      if (i == 40) key = '1;
    end
    cyc(10);

    // All keys on the same edge.
    key = 4'b0000;
    cyc(6);
    chk4("simul_early", press_pulse, 4'b0000);
    cyc(1);
    chk4("simul_press", press_pulse, 4'b1111);
    key = '1;
    cyc(12);

    // Async reset with key 1 pressed and key 0 in its debounce window.
    key = 4'b1101;
    cyc(10);
    chk4("rst_pre", pressed, 4'b0010);
    key = 4'b1100;
    cyc(4);
    #2 reset = 1'b0;
    #1 chk("rst_async", {pressed, press_pulse, release_pulse, repeat_pulse}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    cyc(6);
    chk4("rst_fresh_early", press_pulse, 4'b0000);
    cyc(1);
    chk4("rst_fresh_press", press_pulse, 4'b0011);
    key = '1;
    cyc(12);

    // Random traffic: mix of short bounces and long holds on every key.
    for (int k = 0; k < NK; k++) tmr[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (tmr[k] == 0) begin
          key[k] = ~key[k];
          tmr[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end else begin
          tmr[k] = tmr[k] - 1;
        end
      end
      if (c == 1500) begin
        #2 reset = 1'b0;
        #1 chk("rand_rst", {pressed, press_pulse, release_pulse, repeat_pulse}, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
      end
      cyc(1);
    end

    key = '1;
    cyc(20);
    chk4("final_idle", pressed, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
